err_rail_tx: RTL and testbench
==============================

ERR_RAIL_TX -- requirements
Module: err_rail_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 4: report FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter TMO_W, default 8: width of the ack-timeout counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: an error report is offered this cycle.
REQ-006 SHALL have port in_err, input, 1: report value (1 = timing error detected, 0 = clean).
REQ-007 SHALL have port in_ready, output, 1: FIFO can accept (not full).
REQ-008 SHALL have port err1, output, 1: dual-rail error rail, "error" code.
REQ-009 SHALL have port err0, output, 1: dual-rail error rail, "no error" code.
REQ-010 SHALL have port rreq, output, 1: release request toward goML controller.
REQ-011 SHALL have port sample, output, 1: sample strobe toward goML controller.
REQ-012 SHALL have port goml, input, 1: acknowledge from goML controller, treated as asynchronous.
REQ-013 SHALL have port busy, output, 1: handshake in progress or FIFO non-empty.
REQ-014 SHALL have port timeout, output, 1: sticky; ack not seen within 2^TMO_W-1 cycles.

Function
REQ-015 SHALL push {in_err} into the FIFO when in_valid & in_ready; a push while full is dropped.
REQ-016 SHALL synchronise goml through a 2-flop synchroniser before use; goml_s = synchronised value.
REQ-017 SHALL implement FSM IDLE, SEND, RELEASE, DRAIN.
REQ-018 IDLE: rails 0, rreq 0, sample 0; FIFO non-empty and goml_s=0 -> pop head, go SEND next cycle.
REQ-019 SEND: drive err1=head, err0=~head (exactly one rail high), rreq 0; goml_s=1 -> RELEASE.
REQ-020 RELEASE: err1=err0=0, rreq 1, sample 1; goml_s=0 -> DRAIN.
REQ-021 DRAIN: all outputs 0 for one cycle (return to zero), then IDLE.
REQ-022 SHALL never drive err1 and err0 high in the same cycle, nor either rail high with rreq high.
REQ-023 Minimum latency push-to-rail SHALL be 2 cycles (push cycle, IDLE pop cycle, rail in SEND).
REQ-024 Simultaneous push and pop SHALL be legal at any occupancy, including full (count unchanged).
REQ-025 Pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-026 Timeout counter SHALL clear on each state entry, count in SEND and RELEASE, saturate; at saturation set timeout and force DRAIN.
REQ-027 timeout SHALL clear only on reset.
REQ-028 busy SHALL be 1 when state != IDLE or count != 0.

Reset
REQ-029 rst low SHALL immediately force IDLE, empty FIFO, all rails/rreq/sample 0, timeout 0, in_ready 1, synchroniser flops 0.
REQ-030 Reset mid-handshake SHALL abandon the report in flight; no rail glitch high after deassertion.

Configuration
REQ-031 ERR_RAIL_TX_CNT_EN defined: SHALL add output err_cnt[15:0], count of SEND entries with head=1, saturating at 16'hFFFF, reset 0.
REQ-032 ERR_RAIL_TX_CNT_EN undefined: SHALL have no err_cnt port or counter logic; all other behaviour identical.

Structure
REQ-033 Shared package err_rail_pkg SHALL hold the FSM state typedef (2-bit enum) and rail encoding constants.
REQ-034 FIFO SHALL be sub-module err_rail_fifo (DEPTH param, push/pop/full/empty/count).

Verification
REQ-035 Reset, single push in_err=1, goml tracks err1 with 3-cycle delay -> err1 high 2 cycles after push, then rreq=sample=1, DRAIN, idle; err0 never high.
REQ-036 Fill 4 reports 1,0,1,1 with goml held low -> in_ready=0 after 4th; 5th push dropped; rails emit 1,0,1,1 in order after goml responds.
REQ-037 Push and pop in same cycle while full -> count stays 4, in_ready stays 0.
REQ-038 goml held 0 in SEND for 255 cycles -> timeout=1, DRAIN, IDLE; timeout stays 1 until rst low.
REQ-039 rst low during RELEASE -> rails/rreq/sample 0 same cycle; after release, FIFO empty, busy=0.
REQ-040 With ERR_RAIL_TX_CNT_EN, 3 error and 2 clean reports -> err_cnt=3.

Source files
------------

// File: rtl/err_rail_pkg.sv
// -----------------------------------------------------------------------------
// err_rail_pkg
// Shared definitions for the dual-rail error report transmitter.
//   state_t    : 2-bit FSM state encoding (IDLE, SEND, RELEASE, DRAIN)
//   RAIL_*     : {err1, err0} codes for the dual-rail error rail
//   rail_code(): maps a report bit onto its dual-rail code
// -----------------------------------------------------------------------------
package err_rail_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  // Rail codes are {err1, err0}; NULL is the return-to-zero spacer.
  localparam logic [1:0] RAIL_NULL = 2'b00;
  localparam logic [1:0] RAIL_ERR  = 2'b10;
  localparam logic [1:0] RAIL_OK   = 2'b01;

  function automatic logic [1:0] rail_code(input logic err);
    return err ? RAIL_ERR : RAIL_OK;
  endfunction

endpackage

// File: rtl/err_rail_fifo.sv
// -----------------------------------------------------------------------------
// err_rail_fifo
// Single-bit report FIFO, DEPTH entries (power of two), pointers wrap
// naturally modulo DEPTH.
//   clk, rst : clock, asynchronous active-low reset (empties the FIFO)
//   push, din: write request and data; taken when not full, or when full
//              and a pop happens in the same cycle (occupancy unchanged)
//   pop      : read request, ignored when empty; dout is the current head
//   full, empty, count : occupancy status, count is clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module err_rail_fifo
  import err_rail_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/err_rail_tx.sv
// -----------------------------------------------------------------------------
// err_rail_tx
// Buffers single-bit timing-error reports and sends each one to a goML
// controller as a dual-rail code, using a four-phase handshake:
//   SEND    : one rail high (err1 = error, err0 = clean) until goml rises
//   RELEASE : rails low, rreq/sample high until goml falls
//   DRAIN   : everything low for one cycle, back to IDLE
// A sticky timeout aborts a handshake whose ack never arrives.
//
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   in_valid, in_err  : report offer and value
//   in_ready          : FIFO not full
//   err1, err0        : dual-rail error rail
//   rreq, sample      : release request / sample strobe to goML
//   goml              : ack from goML, asynchronous (2-flop synchronised)
//   busy              : handshake in progress or reports queued
//   timeout           : sticky, set when an ack wait saturates the counter
//   dbg_state         : current FSM state (err_rail_pkg::state_t encoding)
//   err_cnt           : only with ERR_RAIL_TX_CNT_EN defined; number of
//                       error (head=1) reports sent, saturating at 16'hFFFF
//
// Input handshake: a report is taken on a rising edge where in_valid=1 and
// in_ready=1; with the FIFO full (in_ready=0) it is still taken if the FSM
// pops the head in that same cycle, otherwise it is dropped.
// -----------------------------------------------------------------------------
module err_rail_tx
  import err_rail_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TMO_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_err,
  output logic        in_ready,
  output logic        err1,
  output logic        err0,
  output logic        rreq,
  output logic        sample,
  input  logic        goml,
  output logic        busy,
  output logic        timeout,
  output logic [1:0]  dbg_state
`ifdef ERR_RAIL_TX_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  state_t                 state;
  state_t                 state_next;
  logic [1:0]             goml_sync;
  logic                   goml_s;
  logic                   head;
  logic                   cur_err;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] count;
  logic [TMO_W-1:0]       tmo_cnt;
  logic                   waiting;
  logic                   tmo_fire;

  // ---------------------------------------------------------------- FIFO
  err_rail_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .din   (in_err),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign in_ready = ~fifo_full;

  // ------------------------------------------------------ ack synchroniser
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) goml_sync <= 2'b00;
    else      goml_sync <= {goml_sync[0], goml};
  end

  assign goml_s = goml_sync[1];

  // Only start a new report once the controller has dropped its ack.
  assign pop = (state == ST_IDLE) & ~fifo_empty & ~goml_s;

  // ------------------------------------------------------------- timeout
  assign waiting = (state == ST_SEND) | (state == ST_RELEASE);
  // Fires on the edge where the counter would saturate, but only if the
  // handshake is not completing in that same cycle.
  assign tmo_fire = waiting & (tmo_cnt == TMO_MAX - TMO_W'(1)) &
                    (((state == ST_SEND) & ~goml_s) |
                     ((state == ST_RELEASE) & goml_s));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state_next != state) begin
      tmo_cnt <= '0;
    end else if (waiting && tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          timeout <= 1'b0;
    else if (tmo_fire) timeout <= 1'b1;
  end

  // ------------------------------------------------------- FSM: register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // The head is captured at pop time; the FIFO read pointer moves on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cur_err <= 1'b0;
    else if (pop) cur_err <= head;
  end

  // ----------------------------------------------------- FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (pop) state_next = ST_SEND;
      ST_SEND: begin
        if (goml_s)        state_next = ST_RELEASE;
        else if (tmo_fire) state_next = ST_DRAIN;
      end
      ST_RELEASE: if (!goml_s || tmo_fire) state_next = ST_DRAIN;
      ST_DRAIN:   state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------- FSM: outputs
  // Rails are only ever set in SEND and rreq only in RELEASE, so the two
  // can never overlap and at most one rail is high.
  always_comb begin
    {err1, err0} = RAIL_NULL;
    rreq         = 1'b0;
    sample       = 1'b0;
    case (state)
      ST_SEND:    {err1, err0} = rail_code(cur_err);
      ST_RELEASE: begin
        rreq   = 1'b1;
        sample = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (state != ST_IDLE) | (count != '0);
  assign dbg_state = state;

`ifdef ERR_RAIL_TX_CNT_EN
  // Counts SEND entries carrying an error code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   err_cnt <= 16'd0;
    else if (pop && head && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_err_rail_tx.sv
// -----------------------------------------------------------------------------
// tb_err_rail_tx
// Directed bench for err_rail_tx (DEPTH=4, TMO_W=8). A small goML model
// echoes the rail activity back on goml three cycles later when auto_ack
// is set; otherwise goml is driven directly. Every report that reaches the
// rails is checked against the expected queue exp_q. ERR_RAIL_TX_CNT_EN
// enables the err_cnt port and its check.
// -----------------------------------------------------------------------------
module tb_err_rail_tx;
  import err_rail_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_err;
  logic        in_ready;
  logic        err1;
  logic        err0;
  logic        rreq;
  logic        sample;
  logic        goml;
  logic        busy;
  logic        timeout;
  logic [1:0]  dbg_state;
`ifdef ERR_RAIL_TX_CNT_EN
  logic [15:0] err_cnt;
`endif

  int          asserts_n = 0;
  int          fails_n   = 0;
  logic [0:0]  exp_q[$];
  logic        auto_ack;
  logic [2:0]  dly;
  logic        prev_rail;

  // ------------------------------------------------------ clock / reset
  always #5 clk = ~clk;

  err_rail_tx #(.DEPTH(4), .TMO_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_err    (in_err),
    .in_ready  (in_ready),
    .err1      (err1),
    .err0      (err0),
    .rreq      (rreq),
    .sample    (sample),
    .goml      (goml),
    .busy      (busy),
    .timeout   (timeout),
    .dbg_state (dbg_state)
`ifdef ERR_RAIL_TX_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  // ------------------------------------------------------------- checks
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    asserts_n++;
    assert (obs === exp) else begin
      fails_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample 1 ns after the edge, check rail invariants, score
  // every new rail code against exp_q, then advance the goML model.
  task automatic step();
    logic       rail_now;
    logic [0:0] v;
    @(posedge clk);
    #1;
    rail_now = err1 | err0;
    check("rails_exclusive", 32'(err1 & err0), 32'd0);
    check("rail_with_rreq", 32'(rail_now & rreq), 32'd0);
    if (rail_now && !prev_rail) begin
      check("unexpected_report", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        v = exp_q.pop_front();
        check("report_value", 32'(err1), 32'(v));
      end
    end
    prev_rail = rail_now;
    dly       = {dly[1:0], rail_now};
    if (auto_ack) goml = dly[2];
  endtask

  // ------------------------------------------------------------ drivers
  task automatic push_one(input logic e);
    in_valid = 1'b1;
    in_err   = e;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  // ----------------------------------------------------------- sequence
  initial begin
    int   n;
    logic seen_rel, seen_drain, seen_err0;

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_err    = 1'b0;
    goml      = 1'b0;
    auto_ack  = 1'b1;
    dly       = 3'b000;
    prev_rail = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rails", 32'({err1, err0, rreq, sample}), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;

    // --- single error report with an echoing controller
    exp_q.push_back(1'b1);
    push_one(1'b1);
    check("pop_cycle_state", 32'(dbg_state), 32'(ST_IDLE));
    check("pop_cycle_busy", 32'(busy), 32'd1);
    check("pop_cycle_rail", 32'(err1), 32'd0);
    step();
    check("latency_err1", 32'(err1), 32'd1);
    check("latency_err0", 32'(err0), 32'd0);
    check("latency_state", 32'(dbg_state), 32'(ST_SEND));
    seen_rel = 1'b0; seen_drain = 1'b0; seen_err0 = 1'b0; n = 0;
    while (busy !== 1'b0 && n < 40) begin
      step();
      n++;
      if (rreq && sample && !err1 && !err0) seen_rel = 1'b1;
      if (dbg_state == ST_DRAIN && !(err1 | err0 | rreq | sample))
        seen_drain = 1'b1;
      if (err0) seen_err0 = 1'b1;
    end
    check("single_release", 32'(seen_rel), 32'd1);
    check("single_drain", 32'(seen_drain), 32'd1);
    check("single_err0_low", 32'(seen_err0), 32'd0);
    check("single_idle", 32'(busy), 32'd0);
    check("single_q_empty", exp_q.size(), 32'd0);

    // --- fill four reports while goml high holds the controller off
    auto_ack = 1'b0;
    goml     = 1'b1;
    repeat (3) step();
    exp_q.push_back(1'b1); push_one(1'b1);
    exp_q.push_back(1'b0); push_one(1'b0);
    exp_q.push_back(1'b1); push_one(1'b1);
    check("fill3_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(1'b1); push_one(1'b1);
    check("fill4_not_ready", 32'(in_ready), 32'd0);
    check("fill4_state", 32'(dbg_state), 32'(ST_IDLE));
    push_one(1'b0);
    check("fill5_not_ready", 32'(in_ready), 32'd0);
    dly = 3'b000; goml = 1'b0; auto_ack = 1'b1;
    wait_idle(200, "fill_drain_idle");
    check("fill_q_empty", exp_q.size(), 32'd0);

    // --- push and pop in the same cycle while full
    auto_ack = 1'b0;
    goml     = 1'b1;
    repeat (3) step();
    repeat (4) begin
      exp_q.push_back(1'b0);
      push_one(1'b0);
    end
    check("pp_full", 32'(in_ready), 32'd0);
    exp_q.push_back(1'b1);
    in_valid = 1'b1;
    in_err   = 1'b1;
    goml     = 1'b0;
    n = 0;
    while (dbg_state !== ST_SEND && n < 10) begin
      step();
      n++;
      check("pp_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("pp_state_send", 32'(dbg_state), 32'(ST_SEND));
    repeat (2) step();
    check("pp_still_full", 32'(in_ready), 32'd0);
    dly = 3'b000; auto_ack = 1'b1;
    wait_idle(300, "pp_drain_idle");
    check("pp_q_empty", exp_q.size(), 32'd0);

    // --- ack never arrives: timeout after 255 SEND cycles
    auto_ack = 1'b0;
    goml     = 1'b0;
    exp_q.push_back(1'b1);
    push_one(1'b1);
    n = 0;
    while (dbg_state !== ST_SEND && n < 10) begin
      step();
      n++;
    end
    check("tmo_enter_send", 32'(dbg_state), 32'(ST_SEND));
    repeat (254) step();
    check("tmo_255_state", 32'(dbg_state), 32'(ST_SEND));
    check("tmo_255_flag", 32'(timeout), 32'd0);
    step();
    check("tmo_flag_set", 32'(timeout), 32'd1);
    check("tmo_state_drain", 32'(dbg_state), 32'(ST_DRAIN));
    check("tmo_rails_low", 32'({err1, err0, rreq, sample}), 32'd0);
    step();
    check("tmo_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("tmo_busy", 32'(busy), 32'd0);
    repeat (5) step();
    check("tmo_sticky", 32'(timeout), 32'd1);

    // --- reset while in RELEASE abandons the report and the queue
    dly = 3'b000; auto_ack = 1'b1;
    exp_q.push_back(1'b1);
    push_one(1'b1);
    push_one(1'b0);
    n = 0;
    while (rreq !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check("mid_reach_release", 32'(rreq), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_outputs", 32'({err1, err0, rreq, sample}), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_timeout", 32'(timeout), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
`ifdef ERR_RAIL_TX_CNT_EN
    check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    dly = 3'b000; goml = 1'b0; prev_rail = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) step();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("post_rst_rails", 32'({err1, err0}), 32'd0);

    // --- mixed stream: three error and two clean reports
    exp_q.push_back(1'b1); push_one(1'b1);
    exp_q.push_back(1'b0); push_one(1'b0);
    exp_q.push_back(1'b1); push_one(1'b1);
    exp_q.push_back(1'b0); push_one(1'b0);
    exp_q.push_back(1'b1); push_one(1'b1);
    wait_idle(300, "mix_drain_idle");
    check("mix_q_empty", exp_q.size(), 32'd0);
`ifdef ERR_RAIL_TX_CNT_EN
    check("mix_err_cnt", 32'(err_cnt), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts_n, fails_n);
    $finish;
  end

endmodule
